// File: rtl/saper_click_pkg.sv
// saper_click_pkg: shared types and index constants for the mouse click controller.
package saper_click_pkg;
    localparam int IND_W = 5;
    localparam logic [IND_W-1:0] IND_OFF = IND_W'(0);
    localparam logic [IND_W-1:0] IND_OVER = IND_W'(16);
    typedef enum logic {CLICK_REVEAL = 1'b0, CLICK_FLAG = 1'b1} click_type_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED_L, ST_ARMED_R, ST_CANCEL} click_state_t;
endpackage

// File: rtl/cell_click_ctl_btn_edge.sv
// btn_edge: registers a button level and derives one-cycle press/release pulses.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic press_o,
    output logic release_o
);
    logic level_q;
    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level_i;
    end
    assign press_o   = level_i & ~level_q;
    assign release_o = ~level_i & level_q;
endmodule

// File: rtl/cell_click_ctl.sv
// cell_click_ctl: turns button levels and cell indices into validated one-cycle click events.
module cell_click_ctl
    import saper_click_pkg::*;
#(
    parameter int IND_W = saper_click_pkg::IND_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IND_W-1:0] mouse_xpos_ind,
    input  logic [IND_W-1:0] mouse_ypos_ind,
    input  logic             left,
    input  logic             right,
    input  logic [IND_W-1:0] board_size,
    input  logic             game_active,
    output logic             click_valid,
    output logic [IND_W-1:0] click_x,
    output logic [IND_W-1:0] click_y,
    output logic             click_type,
    output logic             armed
);
    logic l_press, l_rel, r_press, r_rel;
    logic cell_ok, same_cell, emit, capture;
    click_type_t emit_type, click_type_q;
    click_state_t state_q, state_d;
    logic [IND_W-1:0] cap_x_q, cap_y_q, click_x_q, click_y_q;
    logic click_valid_q;

    function automatic logic ind_ok(input logic [IND_W-1:0] ind, input logic [IND_W-1:0] size);
        return (ind != IND_W'(IND_OFF)) && (ind != IND_W'(IND_OVER)) && (ind <= size);
    endfunction

    btn_edge u_left (.clk(clk), .rst(rst), .level_i(left), .press_o(l_press), .release_o(l_rel));
    btn_edge u_right (.clk(clk), .rst(rst), .level_i(right), .press_o(r_press), .release_o(r_rel));

    assign cell_ok   = ind_ok(mouse_xpos_ind, board_size) && ind_ok(mouse_ypos_ind, board_size);
    assign same_cell = (mouse_xpos_ind == cap_x_q) && (mouse_ypos_ind == cap_y_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Any press that involves the other button, or an off-board cell, parks in CANCEL.
    always_comb begin
        state_d = state_q;
        if (!game_active) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_IDLE: begin
                    if (l_press && !right && cell_ok)      state_d = ST_ARMED_L;
                    else if (r_press && !left && cell_ok)  state_d = ST_ARMED_R;
                    else if (l_press || r_press)           state_d = ST_CANCEL;
                end
                ST_ARMED_L: state_d = right ? ST_CANCEL : (l_rel ? ST_IDLE : ST_ARMED_L);
                ST_ARMED_R: state_d = left ? ST_CANCEL : (r_rel ? ST_IDLE : ST_ARMED_R);
                ST_CANCEL:  state_d = (!left && !right) ? ST_IDLE : ST_CANCEL;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_type = CLICK_REVEAL;
        capture   = 1'b0;
        if (game_active) begin
            emit = cell_ok && same_cell &&
                   (((state_q == ST_ARMED_L) && l_rel && !right) ||
                    ((state_q == ST_ARMED_R) && r_rel && !left));
            emit_type = (state_q == ST_ARMED_R) ? CLICK_FLAG : CLICK_REVEAL;
            capture   = (state_q == ST_IDLE) && ((state_d == ST_ARMED_L) || (state_d == ST_ARMED_R));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            click_valid_q <= 1'b0;
            click_x_q     <= '0;
            click_y_q     <= '0;
            click_type_q  <= CLICK_REVEAL;
            cap_x_q       <= '0;
            cap_y_q       <= '0;
        end else begin
            click_valid_q <= emit;
            if (emit) begin
                click_x_q    <= cap_x_q;
                click_y_q    <= cap_y_q;
                click_type_q <= emit_type;
            end
            if (capture) begin
                cap_x_q <= mouse_xpos_ind;
                cap_y_q <= mouse_ypos_ind;
            end
        end
    end

    assign click_valid = click_valid_q;
    assign click_x     = click_x_q;
    assign click_y     = click_y_q;
    assign click_type  = click_type_q;
    assign armed       = (state_q == ST_ARMED_L) || (state_q == ST_ARMED_R);
endmodule

// File: tb/tb_cell_click_ctl.sv
// tb_cell_click_ctl: directed gestures checked against a gesture-level model every cycle.
module tb_cell_click_ctl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] x = '0, y = '0, bsz = 5'd8;
    logic       left = 1'b0, right = 1'b0, ga = 1'b1;
    logic       click_valid, click_type, armed;
    logic [4:0] click_x, click_y;
    int checks = 0, errors = 0;

    cell_click_ctl #(.IND_W(5)) dut (
        .clk(clk), .rst(rst), .mouse_xpos_ind(x), .mouse_ypos_ind(y),
        .left(left), .right(right), .board_size(bsz), .game_active(ga),
        .click_valid(click_valid), .click_x(click_x), .click_y(click_y),
        .click_type(click_type), .armed(armed)
    );

    always #5 clk = ~clk;

    // Gesture model: a gesture starts on a press; it is spoiled by the other button or a bad cell.
    int  g_btn, g_x, g_y, m_x, m_y;
    bit  g_spoiled, pl, pr, m_valid, m_type;

    function automatic bit on_board(int i);
        return i >= 1 && i <= int'(bsz) && i != 16;
    endfunction

    always @(posedge clk) begin
        bit lp, rp, rel, other;
        lp = left && !pl;
        rp = right && !pr;
        m_valid = 1'b0;
        if (rst) begin
            g_btn = 0; g_spoiled = 0; m_x = 0; m_y = 0; m_type = 0; pl = 0; pr = 0;
        end else begin
            if (!ga) begin
                g_btn = 0; g_spoiled = 0;
            end else if (g_spoiled) begin
                if (!left && !right) g_spoiled = 0;
            end else if (g_btn == 0) begin
                if (lp || rp) begin
                    if ((left && right) || !on_board(int'(x)) || !on_board(int'(y))) g_spoiled = 1;
                    else begin
                        g_btn = lp ? 1 : 2; g_x = int'(x); g_y = int'(y);
                    end
                end
            end else begin
                other = (g_btn == 1) ? right : left;
                rel   = (g_btn == 1) ? (!left && pl) : (!right && pr);
                if (other) begin
                    g_btn = 0; g_spoiled = 1;
                end else if (rel) begin
                    if (on_board(int'(x)) && on_board(int'(y)) && int'(x) == g_x && int'(y) == g_y) begin
                        m_valid = 1; m_x = g_x; m_y = g_y; m_type = (g_btn == 2);
                    end
                    g_btn = 0;
                end
            end
            pl = left; pr = right;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (click_valid !== m_valid || armed !== (g_btn != 0) || click_type !== m_type ||
                click_x !== 5'(m_x) || click_y !== 5'(m_y)) begin
                errors++;
                $display("FAIL model v/a/t/x/y got %b %b %b %0d %0d expected %b %b %b %0d %0d at %0t",
                         click_valid, armed, click_type, click_x, click_y,
                         m_valid, (g_btn != 0), m_type, m_x, m_y, $time);
            end
        end
    endtask

    task automatic at(input int cx, input int cy);
        x = 5'(cx); y = 5'(cy);
    endtask

    initial begin
        step(2);
        chk("rst_valid", int'(click_valid), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_x", int'(click_x), 0);
        rst = 1'b0;
        step(1);
        // Left reveal at (3,5)
        at(3, 5); left = 1; step(1);
        chk("t1_armed", int'(armed), 1);
        step(3);
        left = 0; step(1);
        chk("t1_valid", int'(click_valid), 1);
        chk("t1_x", int'(click_x), 3);
        chk("t1_y", int'(click_y), 5);
        chk("t1_type", int'(click_type), 0);
        chk("model_pin_valid", int'(m_valid), 1);
        chk("model_pin_x", m_x, 3);
        step(1);
        chk("t1_once", int'(click_valid), 0);
        // Right flag at (8,1)
        at(8, 1); right = 1; step(2);
        right = 0; step(1);
        chk("t2_valid", int'(click_valid), 1);
        chk("t2_type", int'(click_type), 1);
        chk("t2_x", int'(click_x), 8);
        chk("t2_y", int'(click_y), 1);
        // Left at (9,1) is off an 8-wide board
        step(1);
        at(9, 1); left = 1; step(1);
        chk("t2_off_armed", int'(armed), 0);
        left = 0; step(1);
        chk("t2_off_valid", int'(click_valid), 0);
        // Drag from (2,2) to (2,3)
        at(2, 2); left = 1; step(1);
        at(2, 3); step(1);
        left = 0; step(1);
        chk("drag_valid", int'(click_valid), 0);
        chk("drag_hold_x", int'(click_x), 8);
        chk("drag_hold_y", int'(click_y), 1);
        // Chord cancels, then a clean click on the same cell
        at(4, 4); left = 1; step(1);
        right = 1; step(1);
        chk("chord_armed", int'(armed), 0);
        left = 0; right = 0; step(1);
        chk("chord_valid", int'(click_valid), 0);
        left = 1; step(1);
        left = 0; step(1);
        chk("after_chord_valid", int'(click_valid), 1);
        chk("after_chord_x", int'(click_x), 4);
        // Off-board column 0
        at(0, 7); left = 1; step(1);
        chk("off0_armed", int'(armed), 0);
        left = 0; step(1);
        chk("off0_valid", int'(click_valid), 0);
        // Board of 15: 16 rejected, 15 accepted
        bsz = 5'd15; at(16, 16); left = 1; step(1);
        left = 0; step(1);
        chk("over16_valid", int'(click_valid), 0);
        at(15, 15); right = 1; step(1);
        right = 0; step(1);
        chk("edge15_valid", int'(click_valid), 1);
        chk("edge15_x", int'(click_x), 15);
        // Release coinciding with game_active falling
        at(2, 2); left = 1; step(1);
        left = 0; ga = 0; step(1);
        chk("ga_fall_valid", int'(click_valid), 0);
        chk("ga_hold_x", int'(click_x), 15);
        ga = 1; step(1);
        // Reset while held, release as reset drops
        at(5, 5); left = 1; step(1);
        chk("pre_rst_armed", int'(armed), 1);
        rst = 1; step(1);
        chk("rst_mid_x", int'(click_x), 0);
        chk("rst_mid_armed", int'(armed), 0);
        rst = 0; left = 0; step(1);
        chk("rst_rel_valid", int'(click_valid), 0);
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cell_click_ctl.md
# cell_click_ctl

Converts raw mouse button levels plus the per-axis cell indices from the cursor-to-index converters into single-cycle, validated cell click events for the mine board logic. A click is accepted only when press and release both occur on the same on-board cell, with no other button involved. It sits directly downstream of the X and Y index converters and upstream of the board state / reveal logic.

## Interface
Parameters:
- IND_W, 5, width of cell index buses (matches converter output).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mouse_xpos_ind  in  IND_W  column index from X converter; 0 = cursor off board, 1..16.
- mouse_ypos_ind  in  IND_W  row index from Y converter; same encoding.
- left  in  1  left button level, already in clk domain.
- right  in  1  right button level, already in clk domain.
- board_size  in  IND_W  cells per side, legal 1..15; static during a game.
- game_active  in  1  high while clicks may be accepted.
- click_valid  out  1  one-cycle event strobe.
- click_x  out  IND_W  column of accepted click, held until next event.
- click_y  out  IND_W  row of accepted click, held until next event.
- click_type  out  1  0 = reveal (left), 1 = flag (right); held with click_x/y.
- armed  out  1  high while a press is captured and pending release.

## Operation
- Cell valid when 1 <= index <= board_size on both axes; index 0 and 16 are always invalid.
- Button edges: left_q/right_q hold the previous cycle's level; press = level & ~q, release = ~level & q.
- FSM states: IDLE, ARMED_L, ARMED_R, CANCEL.
- IDLE: left press with valid cell and right low -> capture cell, ARMED_L. Right press with valid cell and left low -> capture, ARMED_R. Any press with invalid cell, or both buttons pressed in the same cycle -> CANCEL.
- ARMED_L: right goes high -> CANCEL. Left release: current cell valid and equal to captured -> emit reveal, IDLE; otherwise IDLE with no event.
- ARMED_R: mirror of ARMED_L (left cancels; release emits flag).
- CANCEL: stays until left and right both low, then IDLE; no event.
- game_active low: FSM forced to IDLE every cycle; no event; armed low; held outputs keep their values.
- Cursor moving off-cell while armed does not cancel; only the cell at release matters.
- Emit: click_valid=1 for exactly one cycle; click_x/y = captured cell; click_type set.

## Timing
- Reset values: click_valid 0, click_x 0, click_y 0, click_type 0, armed 0, state IDLE, left_q/right_q 0.
- All outputs registered.
- Release sampled at cycle n -> click_valid high at cycle n+1 only.
- Press sampled at cycle n -> armed high from n+1.
- Back-to-back: a new press can be sampled the cycle after an emit (n+1); maximum rate is one event per 2 cycles.
- Reset mid-operation: any pending capture discarded; no event emitted for a release after reset, because q starts at 0.
- Release and game_active falling in the same cycle: no event.

## Structure
- Package saper_click_pkg: click_type_t enum (CLICK_REVEAL=0, CLICK_FLAG=1), click_state_t enum, IND_W constant, IND_OFF=0 and IND_OVER=16 constants.
- One sub-module btn_edge: registers a level and outputs press/release pulses; instantiated for left and right.
- The FSM, validity compare and output registers stay in cell_click_ctl.

## Test plan
- board_size=8. Left press at (3,5), hold 4 cycles, release at (3,5) -> one click_valid, click_x=3, click_y=5, click_type=0, one cycle after release.
- Right press at (8,1), release at (8,1) -> click_type=1, x=8, y=1. Then left at (9,1) -> no event; armed stays 0; state goes to CANCEL and back to IDLE after release.
- Left press at (2,2), drag, release at (2,3) -> no event; click_x/y keep their previous values.
- Left press at (4,4), right press while left held, release both -> no event. Next left press/release at (4,4) -> event.
- Press at (0,7) (off board) -> no event. Press at (16,16) with board_size=15 -> no event.
- Left press at (5,5) then assert rst for 1 cycle while held, then release -> no event; all outputs equal reset values after rst.
